// File: rtl/sprite_wr_if.sv
// Row-beat stream from the sprite loader into sprite_bank_writer.
// The master drives rows; the slave (the bank writer) returns wr_ready.
interface sprite_wr_if #(
  parameter int WIDTH = 8
);
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             wr_last;

  modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
  modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);
endinterface

// File: rtl/sprite_bank_writer.sv
// Double-buffered sprite row store: fills the back bank from a row stream and swaps it to the front on a vblank rise.
// Optional SPRITE_MIRROR_EN adds i_mirror, which presents the front row bit-reversed.
module sprite_bank_writer #(
  parameter int ROWS   = 16,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  sprite_wr_if.slave        wr,
  input  logic              i_vblank,
  input  logic [ADDR_W-1:0] i_rom_addr,
`ifdef SPRITE_MIRROR_EN
  input  logic              i_mirror,
`endif
  output logic [WIDTH-1:0]  o_rom_bits,
  output logic              o_frame_pending,
  output logic              o_swap_done,
  output logic              o_frame_err
);

  localparam logic [2:0] S_CLEAR   = 3'd0;
  localparam logic [2:0] S_FILL    = 3'd1;
  localparam logic [2:0] S_PAD     = 3'd2;
  localparam logic [2:0] S_PENDING = 3'd3;
  localparam logic [2:0] S_SWAP    = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  logic [2:0]        r_state;
  logic              r_front_sel;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_vblank_q;
  logic              r_swap_done;
  logic              r_frame_err;
  logic [WIDTH-1:0]  r_mem [2][ROWS];

  logic              w_accept;
  logic              w_back;
  logic              w_vblank_rise;
  logic [WIDTH-1:0]  w_row;

  assign wr.wr_ready     = (r_state == S_FILL);
  assign w_accept        = wr.wr_valid && (r_state == S_FILL);
  assign w_back          = ~r_front_sel;
  assign w_vblank_rise   = i_vblank && !r_vblank_q;

  assign o_frame_pending = (r_state == S_PENDING) || (r_state == S_SWAP);
  assign o_swap_done     = r_swap_done;
  assign o_frame_err     = r_frame_err;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_CLEAR;
      r_front_sel <= 1'b0;
      r_wr_ptr    <= '0;
      r_clr_ptr   <= '0;
      r_vblank_q  <= 1'b0;
      r_swap_done <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_vblank_q  <= i_vblank;
      r_swap_done <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          if (r_clr_ptr == LAST_ROW) begin
            r_state   <= S_FILL;
            r_wr_ptr  <= '0;
            r_clr_ptr <= '0;
          end else begin
            r_clr_ptr <= r_clr_ptr + 1'b1;
          end
        end
        S_FILL: begin
          if (w_accept) begin
            // The last physical row always closes the frame, flagged if the sender forgot wr_last.
            if (r_wr_ptr == LAST_ROW) begin
              r_state     <= S_PENDING;
              r_frame_err <= ~wr.wr_last;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
              if (wr.wr_last) r_state <= S_PAD;
            end
          end
        end
        S_PAD: begin
          if (r_wr_ptr == LAST_ROW) r_state <= S_PENDING;
          else                      r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        S_PENDING: begin
          if (w_vblank_rise) r_state <= S_SWAP;
        end
        S_SWAP: begin
          r_front_sel <= ~r_front_sel;
          r_wr_ptr    <= '0;
          r_swap_done <= 1'b1;
          r_state     <= S_FILL;
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  // NOTE: the row storage has no reset branch; the CLEAR state zeroes it row by row, which keeps it RAM-mappable.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[0][r_clr_ptr] <= '0;
      r_mem[1][r_clr_ptr] <= '0;
    end else if (w_accept) begin
      r_mem[w_back][r_wr_ptr] <= wr.wr_data;
    end else if (r_state == S_PAD) begin
      r_mem[w_back][r_wr_ptr] <= '0;
    end
  end

  // NOTE: w_row gets a default before the conditional so no latch is inferred.
  always_comb begin
    w_row = '0;
    if (int'(i_rom_addr) < ROWS) w_row = r_mem[r_front_sel][i_rom_addr];
  end

`ifdef SPRITE_MIRROR_EN
  always_comb begin
    o_rom_bits = w_row;
    if (i_mirror) begin
      for (int i = 0; i < WIDTH; i++) o_rom_bits[i] = w_row[WIDTH-1-i];
    end
  end
`else
  assign o_rom_bits = w_row;
`endif

endmodule

// File: tb/tb_sprite_bank_writer.sv
// Randomized bench for sprite_bank_writer against a frame-image model (front image + pending frame).
// Builds with or without SPRITE_MIRROR_EN.
module tb_sprite_bank_writer;

  localparam int ROWS  = 16;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             vblank;
  logic [3:0]       rom_addr;
  logic [WIDTH-1:0] rom_bits;
  logic             frame_pending;
  logic             swap_done;
  logic             frame_err;
`ifdef SPRITE_MIRROR_EN
  logic             mirror;
`endif

  sprite_wr_if #(.WIDTH(WIDTH)) bus ();

  sprite_bank_writer #(.ROWS(ROWS), .WIDTH(WIDTH), .ADDR_W(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .wr              (bus.slave),
    .i_vblank        (vblank),
    .i_rom_addr      (rom_addr),
`ifdef SPRITE_MIRROR_EN
    .i_mirror        (mirror),
`endif
    .o_rom_bits      (rom_bits),
    .o_frame_pending (frame_pending),
    .o_swap_done     (swap_done),
    .o_frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  bit         rand_vb  = 1'b1;
  logic [7:0] m_front [ROWS];
  logic [7:0] m_pend  [ROWS];
  logic [7:0] frame_data [ROWS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_row(input int a, input string tag);
    logic [7:0] exp;
    rom_addr = 4'(a);
    exp      = m_front[a];
`ifdef SPRITE_MIRROR_EN
    mirror = 1'($urandom_range(0, 1));
    if (mirror) exp = rev8(exp);
`endif
    #1;
    check(tag, rom_bits, exp);
`ifdef SPRITE_MIRROR_EN
    mirror = 1'b0;
`endif
  endtask

  task automatic check_all_rows();
    for (int a = 0; a < ROWS; a++) read_row(a, "rom_row");
  endtask

  task automatic do_reset();
    int n;
    reset          = 1'b1;
    bus.wr_valid   = 1'b0;
    bus.wr_last    = 1'b0;
    tick();
    tick();
    check("rst_ready", bus.wr_ready, 0);
    check("rst_pending", frame_pending, 0);
    check("rst_swap_done", swap_done, 0);
    check("rst_frame_err", frame_err, 0);
    reset = 1'b0;
    n = 0;
    while (!bus.wr_ready && n < 100) begin
      n++;
      tick();
    end
    check("clear_cycles", n, ROWS);
    for (int i = 0; i < ROWS; i++) m_front[i] = 8'h00;
    check_all_rows();
  endtask

  // One beat with random idle gaps; reads a random front row before the edge to show writes never disturb it.
  task automatic send_beat(input logic [7:0] d, input logic last);
    int budget;
    repeat ($urandom_range(0, 2)) tick();
    if (rand_vb) vblank = 1'($urandom_range(0, 1));
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_last  = last;
    budget = 0;
    while (!bus.wr_ready && budget < 64) begin
      tick();
      budget++;
    end
    if (budget >= 64) check("ready_timeout", 0, 1);
    read_row($urandom_range(0, ROWS - 1), "rom_during_write");
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
  endtask

  // Sends frame_data[first..n-1]; the expected image is the rows sent, zero padded.
  task automatic send_frame(input int first, input int n, input bit with_last);
    for (int i = first; i < n; i++) begin
      send_beat(frame_data[i], (i == n - 1) && with_last);
      if (i == n - 1) check("frame_err", frame_err, (n == ROWS) && !with_last);
    end
    for (int i = 0; i < ROWS; i++) m_pend[i] = (i < n) ? frame_data[i] : 8'h00;
  endtask

  task automatic do_swap();
    vblank = 1'b0;
    tick();
    vblank = 1'b1;
    tick();
    check("swap_pending", frame_pending, 1);
    check("swap_early", swap_done, 0);
    tick();
    check("swap_done", swap_done, 1);
    check("pending_clr", frame_pending, 0);
    m_front = m_pend;
    tick();
    check("swap_pulse_end", swap_done, 0);
    vblank = 1'b0;
    check_all_rows();
  endtask

  initial begin
    int n;
    reset        = 1'b1;
    vblank       = 1'b0;
    rom_addr     = '0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.wr_last  = 1'b0;
`ifdef SPRITE_MIRROR_EN
    mirror = 1'b0;
`endif
    do_reset();

    // Full frame with wr_last on the final row: normal end, then swap.
    for (int i = 0; i < ROWS; i++) frame_data[i] = 8'($urandom);
    frame_data[0] = 8'h18;
    frame_data[1] = 8'h3C;
    send_frame(0, ROWS, 1'b1);
    check("full_pending", frame_pending, 1);
    read_row(0, "full_front_unchanged");
    do_swap();

    // Short frame: four rows, remainder padded with zeros.
    for (int i = 0; i < ROWS; i++) frame_data[i] = 8'hFF;
    send_frame(0, 4, 1'b1);
    n = 0;
    while (!frame_pending && n < 50) begin
      check("pad_ready", bus.wr_ready, 0);
      n++;
      tick();
    end
    check("pad_cycles", n, ROWS - 4);
    check("pad_then_ready", bus.wr_ready, 0);
    do_swap();

    // Missing wr_last: one error pulse, frame still swaps.
    for (int i = 0; i < ROWS; i++) frame_data[i] = 8'($urandom);
    send_frame(0, ROWS, 1'b0);
    tick();
    check("frame_err_once", frame_err, 0);
    do_swap();

    // Backpressure: vblank already high on entry to PENDING must not swap.
    rand_vb = 1'b0;
    vblank  = 1'b1;
    for (int i = 0; i < ROWS; i++) frame_data[i] = 8'($urandom);
    send_frame(0, ROWS, 1'b1);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'hA5;
    bus.wr_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_ready", bus.wr_ready, 0);
      check("bp_pending", frame_pending, 1);
      check("bp_no_swap", swap_done, 0);
    end
    vblank = 1'b0;
    tick();
    vblank = 1'b1;
    tick();
    check("bp_swap_state", frame_pending, 1);
    tick();
    check("bp_swap_done", swap_done, 1);
    m_front = m_pend;
    read_row(0, "bp_front_before_beat");
    tick();
    bus.wr_valid = 1'b0;
    read_row(0, "bp_front_after_beat");
    check_all_rows();
    vblank = 1'b0;
    rand_vb = 1'b1;
    for (int i = 0; i < ROWS; i++) frame_data[i] = 8'($urandom);
    frame_data[0] = 8'hA5;
    send_frame(1, ROWS, 1'b1);
    do_swap();

    // Reset mid-frame while the back bank is half written.
    for (int i = 0; i < 7; i++) send_beat(8'($urandom), 1'b0);
    do_reset();

    // Fresh frame after reset; row 0 = 0x01 for the mirror view.
    for (int i = 0; i < ROWS; i++) frame_data[i] = 8'($urandom);
    frame_data[0] = 8'h01;
    send_frame(0, ROWS, 1'b1);
    do_swap();
`ifdef SPRITE_MIRROR_EN
    mirror   = 1'b1;
    rom_addr = 4'd0;
    #1;
    check("mirror_row0", rom_bits, 8'h80);
    mirror = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sprite_bank_writer.md
Name: sprite_bank_writer

Overview:
- Writer side of the sprite bitmap interface. Accepts sprite rows over a valid/ready stream and stores them in a double-buffered row RAM.
- Presents the visible bank through a combinational rom_addr -> rom_bits read port, so it drops in for the fixed bitmap ROM ahead of the sprite renderer.
- Bank swaps happen only on a vertical-blank rising edge, so the renderer never sees a half-written sprite.

Parameters:
- ROWS, 16, sprite height in rows (max rows per frame)
- WIDTH, 8, pixels per row (bits per beat)
- ADDR_W, 4, row address width; ceil(log2(ROWS))

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_valid  in  1  row beat valid
- wr_ready  out  1  block accepts a beat this cycle
- wr_data  in  WIDTH  row pixels, bit WIDTH-1 = leftmost
- wr_last  in  1  beat is the final row of the sprite frame
- vblank  in  1  active-high vertical blank level from the VGA timing path
- rom_addr  in  ADDR_W  renderer row select
- rom_bits  out  WIDTH  front-bank row, combinational from rom_addr
- frame_pending  out  1  complete frame held in back bank, waiting for swap
- swap_done  out  1  one-cycle pulse, the cycle after the bank swap
- frame_err  out  1  one-cycle pulse, row ROWS-1 accepted without wr_last

Behaviour:
- Storage: banks 0 and 1, each ROWS x WIDTH. front_sel picks the bank read by rom_bits; writes go only to bank !front_sel.
- rom_addr >= ROWS reads 0.
- A beat transfers on any clock edge where wr_valid && wr_ready. wr_ready = (state==FILL), combinational from state only.
- States:
  - CLEAR: entered on reset. Zeroes row clr_ptr in both banks each cycle (ROWS cycles), then goes to FILL with wr_ptr=0.
  - FILL: each accepted beat writes back[wr_ptr] and increments wr_ptr.
    - wr_last with wr_ptr<ROWS-1: go to PAD.
    - Beat at wr_ptr==ROWS-1: go to PENDING, whatever wr_last is; frame_err pulses if wr_last==0.
  - PAD: zeroes back rows wr_ptr+1..ROWS-1, one per cycle, then goes to PENDING.
  - PENDING: waits for a vblank rising edge (vblank_q==0 && vblank==1, with vblank_q registered). vblank already high on entry does not count; the next rise is required.
  - SWAP: toggles front_sel, clears wr_ptr, goes to FILL. swap_done is high the following cycle.
- rom_bits shows the new bank from the cycle after the SWAP edge.
- frame_pending = (state==PENDING || state==SWAP).
- A vblank edge during CLEAR, FILL or PAD is ignored; no partial swap ever occurs.
- Reset values:
  - state=CLEAR, front_sel=0, wr_ptr=0, vblank_q=0.
  - wr_ready=0, frame_pending=0, swap_done=0, frame_err=0.
  - rom_bits reads 0 once CLEAR has passed the addressed row.
- Reset mid-operation (any state): the partial frame is discarded, front_sel returns to 0, and both banks are cleared again.
- Simultaneous events:
  - wr_valid with wr_last on the final permitted row: a normal end, no frame_err.
  - rom_addr reads during a write are never affected, because front and back banks differ.
- Latency: an accepted row reaches rom_bits only after its frame's swap, at least one vblank rise later. Minimum is ROWS beats + 2 cycles.

Optional Feature:
- Macro SPRITE_MIRROR_EN.
- Defined: adds input port mirror (1 bit, after rom_addr). When mirror=1, rom_bits is the bit-reversed front row (horizontal flip), still combinational. Storage and handshake are unchanged.
- Undefined: no mirror port; rom_bits is the stored row as written.

Test Plan:
- Reset: hold reset 2 cycles, release -> wr_ready=0 for exactly 16 cycles then 1; rom_bits=0x00 for rom_addr 0..15.
- Full frame: 16 beats 0x18,0x3C,... with wr_last on beat 16 -> frame_pending=1, rom_bits at rom_addr=0 still 0x00. Raise vblank -> swap_done pulse two cycles after the rise; rom_addr=0 reads 0x18, rom_addr=1 reads 0x3C.
- Short frame: 4 beats 0xFF with wr_last on beat 4 -> wr_ready=0 for 12 PAD cycles, then PENDING. After swap, rows 0-3 read 0xFF and rows 4-15 read 0x00.
- Missing last: 16 beats, wr_last never set -> frame_err pulses exactly once, on the cycle after beat 16; frame still swaps normally.
- Backpressure/vblank: wr_valid held high in PENDING with vblank already 1 -> no beat accepted and no swap. Drop and raise vblank -> swap. Next beat is accepted into the now-back bank without changing rom_bits.
- Reset mid-frame: reset after 7 beats of frame 2 (front_sel=1) -> front_sel=0, all rows read 0x00 after CLEAR. With SPRITE_MIRROR_EN and row 0x18 stored as 0x01, mirror=1 reads 0x80.
